// File: rtl/midi_msg_parser_pkg.sv
// Shared constants for the MIDI parser: message types, status nibbles,
// parser state encoding and the special byte values the parser reacts to.
package midi_pkg;

  localparam logic [2:0] MSG_NONE        = 3'd0;
  localparam logic [2:0] MSG_NOTE_OFF    = 3'd1;
  localparam logic [2:0] MSG_NOTE_ON     = 3'd2;
  localparam logic [2:0] MSG_CTRL_CHANGE = 3'd3;
  localparam logic [2:0] MSG_PROG_CHANGE = 3'd4;
  localparam logic [2:0] MSG_PITCH_BEND  = 3'd5;

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [3:0] NIB_POLY_AT  = 4'hA;
  localparam logic [3:0] NIB_CTRL     = 4'hB;
  localparam logic [3:0] NIB_PROG     = 4'hC;
  localparam logic [3:0] NIB_CHAN_AT  = 4'hD;
  localparam logic [3:0] NIB_BEND     = 4'hE;

  localparam logic [7:0] RT_THRESH   = 8'hF8;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;

  typedef enum logic [1:0] {
    ST_NO_STATUS = 2'd0,
    ST_DATA1     = 2'd1,
    ST_DATA2     = 2'd2,
    ST_SYSEX     = 2'd3
  } state_t;

endpackage

// File: rtl/midi_msg_parser_if.sv
// Byte-in / message-out bundle of the MIDI parser, plus the parser state for observation.
// Both directions are plain one-cycle strobes with no backpressure: a byte is taken on
// every cycle i_RX_DV is high, and o_Msg_DV / o_Err are single-cycle pulses.
interface midi_msg_parser_if;
  import midi_pkg::*;

  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_Msg_DV;
  logic [2:0] o_Msg_Type;
  logic [3:0] o_Channel;
  logic [6:0] o_Data1;
  logic [6:0] o_Data2;
  logic       o_Err;
  state_t     o_State;

  modport master (
    output i_RX_DV, i_RX_Byte,
    input  o_Msg_DV, o_Msg_Type, o_Channel, o_Data1, o_Data2, o_Err, o_State
  );

  modport slave (
    input  i_RX_DV, i_RX_Byte,
    output o_Msg_DV, o_Msg_Type, o_Channel, o_Data1, o_Data2, o_Err, o_State
  );

endinterface

// File: rtl/midi_msg_parser_status_decode.sv
// Maps a channel status nibble to its data byte count, message type and whether
// a completed message of that kind is forwarded downstream.
module midi_status_decode
  import midi_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic       o_Two_Bytes,
  output logic [2:0] o_Msg_Type,
  output logic       o_Emit
);

  always_comb begin
    o_Two_Bytes = 1'b1;
    o_Msg_Type  = MSG_NONE;
    o_Emit      = 1'b0;
    case (i_Nibble)
      NIB_NOTE_OFF: begin o_Msg_Type = MSG_NOTE_OFF;    o_Emit = 1'b1; end
      // NOTE_ON with zero velocity is turned into NOTE_OFF by the parser.
      NIB_NOTE_ON:  begin o_Msg_Type = MSG_NOTE_ON;     o_Emit = 1'b1; end
      NIB_POLY_AT:  begin o_Msg_Type = MSG_NONE;        o_Emit = 1'b0; end
      NIB_CTRL:     begin o_Msg_Type = MSG_CTRL_CHANGE; o_Emit = 1'b1; end
      NIB_PROG:     begin o_Msg_Type = MSG_PROG_CHANGE; o_Emit = 1'b1; o_Two_Bytes = 1'b0; end
      NIB_CHAN_AT:  begin o_Msg_Type = MSG_NONE;        o_Emit = 1'b0; o_Two_Bytes = 1'b0; end
      NIB_BEND:     begin o_Msg_Type = MSG_PITCH_BEND;  o_Emit = 1'b1; end
      default:      begin o_Msg_Type = MSG_NONE;        o_Emit = 1'b0; end
    endcase
  end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status, real-time passthrough and SysEx discard.
// Define MIDI_CHANNEL_FILTER_EN to emit only messages on channel CHANNEL (omni otherwise).
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  midi_msg_parser_if.slave   bus
);

`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  state_t     r_State;
  logic [7:0] r_Status;
  logic [6:0] r_Data1;
  logic       r_Msg_DV;
  logic [2:0] r_Msg_Type;
  logic [3:0] r_Channel;
  logic [6:0] r_Out_D1;
  logic [6:0] r_Out_D2;
  logic       r_Err;

  logic [7:0] w_Byte;
  logic       w_Real_Time;
  logic       w_Chan_Status;
  logic       w_Two_Bytes;
  logic [2:0] w_Dec_Type;
  logic       w_Emit;
  logic       w_Chan_Ok;
  logic [6:0] w_Out_D1;
  logic [6:0] w_Out_D2;
  logic [2:0] w_Out_Type;

  assign w_Byte        = bus.i_RX_Byte;
  assign w_Real_Time   = (w_Byte >= RT_THRESH);
  assign w_Chan_Status = w_Byte[7] && (w_Byte < SYSEX_START);
  assign w_Chan_Ok     = !FILTER_EN || (r_Status[3:0] == CHANNEL);

  midi_status_decode u_decode (
    .i_Nibble    (r_Status[7:4]),
    .o_Two_Bytes (w_Two_Bytes),
    .o_Msg_Type  (w_Dec_Type),
    .o_Emit      (w_Emit)
  );

  // Fields of the message completed by the current data byte, if it completes one.
  always_comb begin
    w_Out_D1   = (r_State == ST_DATA2) ? r_Data1 : w_Byte[6:0];
    w_Out_D2   = (r_State == ST_DATA2) ? w_Byte[6:0] : 7'd0;
    w_Out_Type = w_Dec_Type;
    if (w_Dec_Type == MSG_NOTE_ON && w_Out_D2 == 7'd0) w_Out_Type = MSG_NOTE_OFF;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State    <= ST_NO_STATUS;
      r_Status   <= 8'd0;
      r_Data1    <= 7'd0;
      r_Msg_DV   <= 1'b0;
      r_Msg_Type <= MSG_NONE;
      r_Channel  <= 4'd0;
      r_Out_D1   <= 7'd0;
      r_Out_D2   <= 7'd0;
      r_Err      <= 1'b0;
    end else begin
      r_Msg_DV <= 1'b0;
      r_Err    <= 1'b0;
      if (bus.i_RX_DV && !w_Real_Time) begin
        if (w_Byte[7]) begin
          if (w_Chan_Status) begin
            r_Status <= w_Byte;
            r_State  <= ST_DATA1;
          end else begin
            r_Status <= 8'd0;
            r_State  <= (w_Byte == SYSEX_START) ? ST_SYSEX : ST_NO_STATUS;
          end
        end else begin
          case (r_State)
            ST_NO_STATUS: r_Err <= 1'b1;
            ST_SYSEX:     r_State <= ST_SYSEX;
            ST_DATA1, ST_DATA2: begin
              if (r_State == ST_DATA1) r_Data1 <= w_Byte[6:0];
              if (r_State == ST_DATA1 && w_Two_Bytes) begin
                r_State <= ST_DATA2;
              end else begin
                // Stay ready for running-status data after every completed message.
                r_State <= ST_DATA1;
                if (w_Emit && w_Chan_Ok) begin
                  r_Msg_DV   <= 1'b1;
                  r_Msg_Type <= w_Out_Type;
                  r_Channel  <= r_Status[3:0];
                  r_Out_D1   <= w_Out_D1;
                  r_Out_D2   <= w_Out_D2;
                end
              end
            end
            default: r_State <= ST_NO_STATUS;
          endcase
        end
      end
    end
  end

  assign bus.o_Msg_DV   = r_Msg_DV;
  assign bus.o_Msg_Type = r_Msg_Type;
  assign bus.o_Channel  = r_Channel;
  assign bus.o_Data1    = r_Out_D1;
  assign bus.o_Data2    = r_Out_D2;
  assign bus.o_Err      = r_Err;
  assign bus.o_State    = r_State;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: a byte-level MIDI model predicts every output
// cycle, and literal checks after each test sequence pin both the model and the DUT.
module tb_midi_msg_parser;
  import midi_pkg::*;

  localparam logic [3:0] TB_CHANNEL = 4'd3;

  logic i_Clk;
  logic i_Rst;
  midi_msg_parser_if bus ();

  midi_msg_parser #(.CHANNEL(TB_CHANNEL)) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial i_Clk = 1'b0;
  always #20 i_Clk = ~i_Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_seen = 0;
  int err_seen = 0;

  // ---------------- model state ----------------
  int         m_status;
  bit         m_sysex;
  logic [7:0] m_data[$];
  logic       exp_dv, exp_err;
  logic [2:0] exp_type;
  logic [3:0] exp_ch;
  logic [6:0] exp_d1, exp_d2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_status = 0; m_sysex = 0; m_data.delete();
    exp_dv = 0; exp_err = 0; exp_type = 0; exp_ch = 0; exp_d1 = 0; exp_d2 = 0;
  endtask

  // Applies the MIDI protocol rules to one received byte.
  task automatic model_step(input logic [7:0] b);
    int need, hi, t;
    bit emit;
    logic [6:0] d1, d2;
    if (b >= 8'hF8) return;
    if (b >= 8'h80) begin
      m_data.delete();
      m_status = (b < 8'hF0) ? int'(b) : 0;
      m_sysex  = (b == 8'hF0);
      return;
    end
    if (m_sysex) return;
    if (m_status == 0) begin exp_err = 1; return; end
    m_data.push_back(b);
    hi = m_status / 16;
    need = (hi == 12 || hi == 13) ? 1 : 2;
    if (m_data.size() < need) return;
    d1 = m_data[0][6:0];
    d2 = (need == 2) ? m_data[1][6:0] : 7'd0;
    m_data.delete();
    emit = 1; t = 0;
    case (hi)
      8:  t = 1;
      9:  t = (d2 != 0) ? 2 : 1;
      11: t = 3;
      12: t = 4;
      14: t = 5;
      default: emit = 0;
    endcase
`ifdef MIDI_CHANNEL_FILTER_EN
    if ((m_status % 16) != int'(TB_CHANNEL)) emit = 0;
`endif
    if (emit) begin
      exp_dv = 1; exp_type = 3'(t); exp_ch = 4'(m_status % 16); exp_d1 = d1; exp_d2 = d2;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge i_Clk);
    bus.i_RX_DV = 1'b1;
    bus.i_RX_Byte = b;
    @(posedge i_Clk);
    model_step(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_Clk);
      bus.i_RX_DV = 1'b0;
      bus.i_RX_Byte = 8'h00;
    end
  endtask

  task automatic send_seq(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (gap > 0) idle(gap);
    end
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    i_Rst = 1'b1;
    bus.i_RX_DV = 1'b0;
    model_reset();
    #1;
    check("rst_msg_dv", 32'(bus.o_Msg_DV), 0);
    check("rst_type",   32'(bus.o_Msg_Type), 0);
    check("rst_data",   {bus.o_Channel, bus.o_Data1, bus.o_Data2, bus.o_Err}, 0);
    check("rst_state",  32'(bus.o_State), 32'(ST_NO_STATUS));
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
  endtask

  // Literal expectation for the held message fields, applied to both model and DUT.
  task automatic check_last(input string name, input int t, input int ch, input int d1, input int d2);
    check({name, "_type"}, 32'(bus.o_Msg_Type), 32'(t));
    check({name, "_ch"},   32'(bus.o_Channel), 32'(ch));
    check({name, "_d1"},   32'(bus.o_Data1), 32'(d1));
    check({name, "_d2"},   32'(bus.o_Data2), 32'(d2));
    check({name, "_model"}, {exp_type, exp_ch, exp_d1, exp_d2}, {3'(t), 4'(ch), 7'(d1), 7'(d2)});
  endtask

  task automatic check_counts(input string name, input int dvs, input int errs);
    check({name, "_dv_count"},  32'(dv_seen), 32'(dvs));
    check({name, "_err_count"}, 32'(err_seen), 32'(errs));
  endtask

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge i_Clk) begin
    if (!i_Rst) begin
      if (bus.o_Msg_DV === 1'b1) dv_seen++;
      if (bus.o_Err === 1'b1) err_seen++;
      check("cyc_msg_dv", 32'(bus.o_Msg_DV), 32'(exp_dv));
      check("cyc_err",    32'(bus.o_Err), 32'(exp_err));
      check("cyc_fields", {bus.o_Msg_Type, bus.o_Channel, bus.o_Data1, bus.o_Data2},
                          {exp_type, exp_ch, exp_d1, exp_d2});
      exp_dv  = 1'b0;
      exp_err = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  localparam int FILT =
`ifdef MIDI_CHANNEL_FILTER_EN
    1;
`else
    0;
`endif

  initial begin
    i_Rst = 1'b1;
    bus.i_RX_DV = 1'b0;
    bus.i_RX_Byte = 8'h00;
    model_reset();
    do_reset();
    idle(1);
    check_counts("after_reset", 0, 0);

    if (FILT == 0) begin
      send_seq('{8'h92, 8'h3C, 8'h64}, 0);
      check_last("note_on", 2, 2, 8'h3C, 8'h64);
      check_counts("note_on", 1, 0);

      send_seq('{8'h90, 8'h40, 8'h7F, 8'h40, 8'h00}, 1);
      check_last("running", 1, 0, 8'h40, 8'h00);
      check_counts("running", 3, 0);

      send_seq('{8'hB1, 8'hF8, 8'h07, 8'hFE, 8'h55}, 0);
      check_last("ctrl_rt", 3, 1, 8'h07, 8'h55);
      check_counts("ctrl_rt", 4, 0);

      send_seq('{8'hC5, 8'h0A, 8'h0B}, 0);
      check_last("prog", 4, 5, 8'h0B, 8'h00);
      check_counts("prog", 6, 0);

      send_seq('{8'hE0, 8'h00, 8'h40}, 2);
      check_last("bend", 5, 0, 8'h00, 8'h40);
      check_counts("bend", 7, 0);

      do_reset();
      send_seq('{8'h3C}, 0);
      check_counts("orphan", 7, 1);
      send_seq('{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h3C}, 0);
      check_counts("sysex", 7, 2);

      send_seq('{8'hA0, 8'h10, 8'h20, 8'hD3, 8'h05, 8'hF2, 8'h05}, 0);
      check_counts("silent", 7, 3);
      check_last("silent", 0, 0, 8'h00, 8'h00);
    end

    // Channel filter scenario; omni build emits both messages.
    do_reset();
    send_seq('{8'h93, 8'h3C, 8'h40}, 0);
    check_last("ch3", 2, 3, 8'h3C, 8'h40);
    send_seq('{8'h94, 8'h3C, 8'h41}, 0);
    if (FILT == 0) check_last("ch4", 2, 4, 8'h3C, 8'h41);
    else           check_last("ch4_dropped", 2, 3, 8'h3C, 8'h40);

    send_seq('{8'h93}, 0);
    do_reset();
    send_seq('{8'h3C, 8'h40}, 0);
    if (FILT == 0) check_counts("rst_mid", 9, 5);
    else           check_counts("rst_mid", 1, 2);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
